// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC sequencer owning the imem handshake, queue back-pressure and redirect squash
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic [31:0] dec_pc_next,
    input  logic        iq_full,
    output logic        iq_push,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    typedef enum logic [1:0] {S_WAIT, S_HOLD, S_KILL} state_t;

    state_t      state_q;
    logic [31:0] req_pc_q, kill_pc_q, hold_inst_q, hold_pc_q, tgt;

    assign tgt = redirect_pc & 32'hffff_fffc;

    // Request/decode/push outputs, all forced quiet while reset is held
    always_comb begin
        imem_addr  = req_pc_q;
        imem_rmask = (!rst && state_q != S_HOLD) ? 4'hf : 4'h0;
        dec_inst   = rst ? '0 : (state_q == S_HOLD) ? hold_inst_q : imem_rdata;
        dec_pc     = rst ? '0 : (state_q == S_HOLD) ? hold_pc_q : req_pc_q;
        iq_push    = !rst && !redirect_valid && !iq_full &&
                     ((state_q == S_WAIT && imem_resp) || state_q == S_HOLD);
    end

    // Fetch FSM: redirect outranks everything; the youngest redirect target wins
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_WAIT;
            req_pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            if (state_q == S_HOLD || imem_resp) begin
                state_q  <= S_WAIT;
                req_pc_q <= tgt;
            end else begin
                state_q   <= S_KILL;
                kill_pc_q <= tgt;
            end
        end else begin
            case (state_q)
                S_WAIT: if (imem_resp) begin
                    if (!iq_full) begin
                        req_pc_q <= dec_pc_next;
                    end else begin
                        hold_inst_q <= imem_rdata;
                        hold_pc_q   <= req_pc_q;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: if (!iq_full) begin
                    req_pc_q <= dec_pc_next;
                    state_q  <= S_WAIT;
                end
                S_KILL: if (imem_resp) begin
                    req_pc_q <= kill_pc_q;
                    state_q  <= S_WAIT;
                end
                default: state_q <= S_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios against a 2-cycle-latency memory model
module tb_fetch_ctrl;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] imem_addr, imem_rdata = '0, dec_inst, dec_pc, dec_pc_next = '0, redirect_pc = '0;
    logic [3:0]  imem_rmask;
    logic        imem_resp = 0, iq_full = 0, iq_push, redirect_valid = 0;

    int          vectors = 0, miscompares = 0, lat = 0;
    logic        rst_v, full, redir, inj;
    logic [31:0] rpc, br_pc, br_tgt, exp_addr;
    logic [31:0] o_addr, o_pc, o_inst;
    logic [3:0]  o_rmask;
    logic        o_push, exp_push;

    localparam logic [31:0] K = 32'h5a5a_0000;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp), .dec_inst(dec_inst), .dec_pc(dec_pc),
        .dec_pc_next(dec_pc_next), .iq_full(iq_full), .iq_push(iq_push),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        rst = rst_v;
        imem_resp = inj || (imem_rmask == 4'hf && lat == 2);
        imem_rdata = imem_resp ? (imem_addr ^ K) : 32'hdead_beef;
        dec_pc_next = (dec_pc == br_pc) ? br_tgt : dec_pc + 32'd4;
        iq_full = full;
        redirect_valid = redir;
        redirect_pc = rpc;
        #1;
        o_addr = imem_addr; o_rmask = imem_rmask; o_push = iq_push; o_pc = dec_pc; o_inst = dec_inst;
        lat = (imem_rmask == 4'hf && !imem_resp) ? lat + 1 : 0;
        @(posedge clk);
    endtask

    task automatic do_reset();
        rst_v = 1; full = 0; redir = 0; inj = 0; rpc = '0;
        br_pc = 32'hffff_ffff; br_tgt = '0; lat = 0;
        tick(); tick();
        rst_v = 0;
    endtask

    task automatic test_reset();
        rst_v = 1; full = 0; redir = 0; inj = 1; rpc = '0; br_pc = 32'hffff_ffff; lat = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (o_rmask !== 4'h0) begin miscompares++; $display("FAIL reset_rmask got=%h exp=0", o_rmask); end
            vectors++; if (o_push !== 1'b0) begin miscompares++; $display("FAIL reset_push got=%b exp=0", o_push); end
            vectors++; if (o_inst !== 32'h0) begin miscompares++; $display("FAIL reset_inst got=%h exp=0", o_inst); end
            vectors++; if (o_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got=%h exp=0", o_pc); end
        end
        inj = 0; rst_v = 0; lat = 0;
        tick();
        vectors++; if (o_addr !== 32'h1eceb000) begin miscompares++; $display("FAIL first_addr got=%h exp=1eceb000", o_addr); end
        vectors++; if (o_rmask !== 4'hf) begin miscompares++; $display("FAIL first_rmask got=%h exp=f", o_rmask); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_addr = 32'h1eceb000 + 32'(4 * (i / 3));
            exp_push = (i % 3 == 2);
            vectors++; if (o_addr !== exp_addr) begin miscompares++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, o_addr, exp_addr); end
            vectors++; if (o_push !== exp_push) begin miscompares++; $display("FAIL stream_push[%0d] got=%b exp=%b", i, o_push, exp_push); end
            if (exp_push) begin
                vectors++; if (o_pc !== exp_addr) begin miscompares++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, o_pc, exp_addr); end
                vectors++; if (o_inst !== (exp_addr ^ K)) begin miscompares++; $display("FAIL stream_inst[%0d] got=%h exp=%h", i, o_inst, exp_addr ^ K); end
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] tbl [9] = '{32'h1eceb000, 32'h1eceb000, 32'h1eceb000, 32'h1eceb004, 32'h1eceb004,
                                  32'h1eceb004, 32'h1eceb040, 32'h1eceb040, 32'h1eceb040};
        do_reset();
        br_pc = 32'h1eceb004; br_tgt = 32'h1eceb040;
        for (int i = 0; i < 9; i++) begin
            tick();
            vectors++; if (o_addr !== tbl[i]) begin miscompares++; $display("FAIL branch_addr[%0d] got=%h exp=%h", i, o_addr, tbl[i]); end
        end
        vectors++; if (o_push !== 1'b1 || o_pc !== 32'h1eceb040) begin miscompares++; $display("FAIL branch_push got=%b/%h exp=1/1eceb040", o_push, o_pc); end
    endtask

    task automatic test_hold();
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        full = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (o_push !== 1'b0) begin miscompares++; $display("FAIL hold_push[%0d] got=%b exp=0", i, o_push); end
            if (i > 0) begin
                vectors++; if (o_rmask !== 4'h0) begin miscompares++; $display("FAIL hold_rmask[%0d] got=%h exp=0", i, o_rmask); end
            end
        end
        full = 0;
        tick();
        vectors++; if (o_push !== 1'b1) begin miscompares++; $display("FAIL hold_release_push got=%b exp=1", o_push); end
        vectors++; if (o_pc !== 32'h1eceb008) begin miscompares++; $display("FAIL hold_pc got=%h exp=1eceb008", o_pc); end
        vectors++; if (o_inst !== (32'h1eceb008 ^ K)) begin miscompares++; $display("FAIL hold_inst got=%h exp=%h", o_inst, 32'h1eceb008 ^ K); end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (o_push !== 1'b0 || o_addr !== 32'h1eceb00c) begin miscompares++; $display("FAIL hold_once[%0d] got=%b/%h exp=0/1eceb00c", i, o_push, o_addr); end
        end
        tick();
        vectors++; if (o_push !== 1'b1 || o_pc !== 32'h1eceb00c) begin miscompares++; $display("FAIL hold_next got=%b/%h exp=1/1eceb00c", o_push, o_pc); end
    endtask

    task automatic test_redirect_kill();
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        redir = 1; rpc = 32'h1eceb103;
        tick();
        redir = 0;
        vectors++; if (o_push !== 1'b0 || o_addr !== 32'h1eceb00c) begin miscompares++; $display("FAIL kill_enter got=%b/%h exp=0/1eceb00c", o_push, o_addr); end
        tick();
        vectors++; if (o_addr !== 32'h1eceb00c || o_rmask !== 4'hf) begin miscompares++; $display("FAIL kill_hold_addr got=%h/%h exp=1eceb00c/f", o_addr, o_rmask); end
        vectors++; if (o_push !== 1'b0) begin miscompares++; $display("FAIL kill_push got=%b exp=0", o_push); end
        tick();
        vectors++; if (o_addr !== 32'h1eceb100) begin miscompares++; $display("FAIL kill_target got=%h exp=1eceb100", o_addr); end
        tick(); tick();
        vectors++; if (o_push !== 1'b1 || o_pc !== 32'h1eceb100) begin miscompares++; $display("FAIL kill_resume got=%b/%h exp=1/1eceb100", o_push, o_pc); end
    endtask

    task automatic test_redirect_resp_hold();
        do_reset();
        tick(); tick();
        redir = 1; rpc = 32'h1eceb120;
        tick();
        redir = 0;
        vectors++; if (o_push !== 1'b0) begin miscompares++; $display("FAIL rr_push got=%b exp=0", o_push); end
        tick();
        vectors++; if (o_addr !== 32'h1eceb120) begin miscompares++; $display("FAIL rr_addr got=%h exp=1eceb120", o_addr); end
        tick();
        full = 1;
        tick();
        full = 0; redir = 1; rpc = 32'h1eceb182;
        tick();
        redir = 0;
        vectors++; if (o_push !== 1'b0 || o_rmask !== 4'h0) begin miscompares++; $display("FAIL hr_push got=%b/%h exp=0/0", o_push, o_rmask); end
        tick();
        vectors++; if (o_addr !== 32'h1eceb180 || o_rmask !== 4'hf) begin miscompares++; $display("FAIL hr_addr got=%h/%h exp=1eceb180/f", o_addr, o_rmask); end
        tick(); tick();
        vectors++; if (o_push !== 1'b1 || o_pc !== 32'h1eceb180) begin miscompares++; $display("FAIL hr_resume got=%b/%h exp=1/1eceb180", o_push, o_pc); end
    endtask

    task automatic test_double_redirect_rst();
        do_reset();
        redir = 1; rpc = 32'h1eceb200;
        tick();
        rpc = 32'h1eceb300;
        tick();
        redir = 0;
        tick();
        vectors++; if (o_push !== 1'b0) begin miscompares++; $display("FAIL dr_push got=%b exp=0", o_push); end
        tick();
        vectors++; if (o_addr !== 32'h1eceb300) begin miscompares++; $display("FAIL dr_addr got=%h exp=1eceb300", o_addr); end
        rst_v = 1; inj = 1;
        tick();
        rst_v = 0; inj = 0;
        vectors++; if (o_push !== 1'b0 || o_rmask !== 4'h0) begin miscompares++; $display("FAIL mid_rst got=%b/%h exp=0/0", o_push, o_rmask); end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (o_addr !== 32'h1eceb000 || o_push !== 1'b0) begin miscompares++; $display("FAIL post_rst[%0d] got=%h/%b exp=1eceb000/0", i, o_addr, o_push); end
        end
        tick();
        vectors++; if (o_push !== 1'b1 || o_pc !== 32'h1eceb000) begin miscompares++; $display("FAIL post_rst_push got=%b/%h exp=1/1eceb000", o_push, o_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_branch();
        test_hold();
        test_redirect_kill();
        test_redirect_resp_hold();
        test_double_redirect_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Front-end sequencer that owns the fetch PC and the instruction-memory request handshake. It feeds fetched words and their PC to the combinational decode stage, then pushes into the instruction queue. It takes the next PC from decode's prediction, stalls on a full queue, and squashes in-flight fetches on a backend redirect (mispredict/flush).

Parameters:
RESET_PC, 32'h1eceb000, first fetch address after reset
(no others)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_addr  out  32  fetch address, word aligned
imem_rmask  out  4  4'hf while a request is outstanding, else 0
imem_rdata  in  32  fetched word, valid when imem_resp
imem_resp  in  1  one-cycle response strobe
dec_inst  out  32  word to decode: live imem_rdata in WAIT, hold buffer in HOLD
dec_pc  out  32  PC of dec_inst
dec_pc_next  in  32  decode's next PC for dec_inst (pc+4 or pc+b_imm)
iq_full  in  1  instruction queue cannot accept
iq_push  out  1  push dec_inst/decode output into queue this cycle
redirect_valid  in  1  backend flush request
redirect_pc  in  32  restart address; bits [1:0] ignored and forced to 0

Behaviour:
- Reset: state=WAIT, req_pc=RESET_PC. While rst is high: imem_rmask=0, iq_push=0, dec_inst=0, dec_pc=0. First request is visible in the cycle after rst falls.
- States: WAIT (request outstanding, result wanted), HOLD (word buffered, queue full, no request outstanding), KILL (request outstanding, result discarded).
- imem_rmask=4'hf in WAIT and KILL, 0 in HOLD. imem_addr=req_pc, stable until imem_resp.
- Exactly one request is outstanding at a time. A new request starts the cycle after the resp that retires the previous one.
- WAIT, imem_resp=1, iq_full=0, no redirect:
  - iq_push=1 the same cycle (combinational).
  - req_pc <= dec_pc_next. Stay WAIT.
  - Sustained throughput is 1 instruction per (memory latency + 1) cycles.
- WAIT, imem_resp=1, iq_full=1:
  - Latch rdata and req_pc into the hold buffer. Go to HOLD.
- HOLD:
  - dec_inst/dec_pc come from the buffer.
  - When iq_full=0: iq_push=1, req_pc <= dec_pc_next, go to WAIT.
  - The buffer is pushed exactly once.
- Redirect has top priority in every state. req_pc/kill target <= {redirect_pc[31:2],2'b00}, and no push happens that cycle.
  - WAIT, no resp: save the target and go to KILL. imem_addr keeps the old address until resp.
  - WAIT with resp in the same cycle: drop the word, go to WAIT at the target.
  - HOLD: drop the buffer, go to WAIT at the target.
  - KILL: overwrite the saved target (youngest redirect wins). Stay KILL, or go to WAIT at the new target if resp arrives the same cycle.
- KILL, imem_resp=1: discard the word, iq_push=0, req_pc <= saved target, go to WAIT.
- iq_push is never asserted in KILL, or in any cycle with redirect_valid=1.
- dec_pc_next is used only in a cycle where iq_push=1.
- PC arithmetic is 32-bit and wraps modulo 2^32. Decode computes it; this block does no adding.
- rst mid-transaction: abandon the state immediately and return to WAIT at RESET_PC. Any late imem_resp arriving in the reset cycle is ignored.

Test Plan:
- Reset release, memory latency 2, dec_pc_next=pc+4 -> imem_addr goes 1eceb000, 1eceb004, 1eceb008; one iq_push per 3 cycles with matching dec_pc.
- Predicted branch at 1eceb004 with dec_pc_next=1eceb040 -> the next imem_addr is 1eceb040, and 1eceb008 is never requested.
- iq_full=1 when the resp for 1eceb008 arrives, held 5 cycles -> HOLD, imem_rmask=0, iq_push=0 for 5 cycles, then a single push of the buffered word with dec_pc=1eceb008.
- redirect_pc=32'h1eceb103 one cycle after a request to 1eceb00c -> imem_addr stays 1eceb00c until resp, that word is not pushed, then imem_addr=1eceb100.
- Redirect in the same cycle as imem_resp, and redirect while in HOLD -> no push, next imem_addr = redirect target.
- Two redirects (1eceb200, then 1eceb300) during one KILL, followed by rst asserted mid-WAIT -> fetch resumes at 1eceb300; after rst, imem_addr=1eceb000 and no stale push.
